// File: rtl/jt12_bus_pkg.sv
// Shared types and constants for the jt12 register-write sequencer.
// A request is {port, reg, val}; the FSM walks one request through two bus writes.
package jt12_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_AWR,
        ST_AGAP,
        ST_DPOLL,
        ST_DWR,
        ST_DGAP
    } state_e;

    localparam logic ADDR_SEL = 1'b0;
    localparam logic DATA_SEL = 1'b1;
    localparam int   BUSY_BIT = 7;
    localparam int   ENTRY_W  = 17;

    typedef struct packed {
        logic       port;
        logic [7:0] regn;
        logic [7:0] val;
    } req_t;

endpackage

// File: rtl/jt12_bus_fifo.sv
// Synchronous FIFO of 2^AW request entries with registered occupancy count.
// Push on full and pop on empty are ignored; dout always shows the head entry.
module jt12_bus_fifo
    import jt12_bus_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic               mclk,
    input  logic               rst0,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic [AW:0]        count
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

    logic [ENTRY_W-1:0] mem_q [2**AW];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q;
    logic               push_ok, pop_ok;

    assign full    = (count_q == DEPTH);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge mclk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo the depth on their own.
    always_ff @(posedge mclk or posedge rst0) begin
        if (rst0) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/jt12_bus_sequencer.sv
// Replays queued {port,reg,val} writes onto the jt12 CPU bus, polling the busy
// flag before each address and data write; all bus activity is paced by clk_en.
module jt12_bus_sequencer
    import jt12_bus_pkg::*;
#(
    parameter int AW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       mclk,
    input  logic       rst0,
    input  logic       clk_en,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_port,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_val,
    output logic       cs_n,
    output logic       wr_n,
    output logic [1:0] addr,
    output logic [7:0] bus_dout,
    input  logic [7:0] bus_din,
    output logic       idle,
    output logic       busy_err,
    output state_e     dbg_state
);

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e          state_q;
    req_t            cur_q;
    logic [TO_W-1:0] cnt_q;
    logic            cs_n_q, wr_n_q, idle_q, busy_err_q;
    logic [1:0]      addr_q;
    logic [7:0]      dout_q;

    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_empty, fifo_full;
    logic [AW:0]        fifo_count;
    logic               push_w, pop_w, busy_w, tmo_hit, goes_idle, next_empty;
    logic               unused_status;
    req_t               head;

    assign head          = req_t'(fifo_dout);
    assign req_ready     = !fifo_full;
    assign push_w        = req_valid && req_ready;
    assign pop_w         = clk_en && !fifo_empty && (state_q == ST_IDLE || state_q == ST_DGAP);
    assign busy_w        = bus_din[BUSY_BIT];
    assign unused_status = ^bus_din[6:0];
    assign tmo_hit       = (cnt_q == TO_W'(TIMEOUT - 1));

    // idle is registered, so it is built from the state and occupancy that
    // will hold after this edge.
    assign goes_idle  = (state_q == ST_IDLE && !pop_w) ||
                        (state_q == ST_DGAP && clk_en && fifo_empty);
    assign next_empty = (fifo_count == '0 && !push_w) ||
                        (fifo_count == (AW+1)'(1) && pop_w && !push_w);

    jt12_bus_fifo #(.AW(AW)) u_fifo (
        .mclk  (mclk),
        .rst0  (rst0),
        .push  (push_w),
        .pop   (pop_w),
        .din   ({req_port, req_reg, req_val}),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge mclk or posedge rst0) begin
        if (rst0) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            cnt_q      <= '0;
            cs_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            addr_q     <= 2'b00;
            dout_q     <= 8'h00;
            idle_q     <= 1'b1;
            busy_err_q <= 1'b0;
        end else begin
            idle_q <= goes_idle && next_empty;
            if (clk_en) begin
                case (state_q)
                    ST_IDLE, ST_DGAP: begin
                        cs_n_q <= 1'b1;
                        wr_n_q <= 1'b1;
                        if (!fifo_empty) begin
                            cur_q   <= head;
                            cnt_q   <= '0;
                            state_q <= ST_POLL;
                            cs_n_q  <= 1'b0;
                            addr_q  <= {head.port, ADDR_SEL};
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_POLL: begin
                        if (!busy_w || tmo_hit) begin
                            if (busy_w) busy_err_q <= 1'b1;
                            state_q <= ST_AWR;
                            wr_n_q  <= 1'b0;
                            addr_q  <= {cur_q.port, ADDR_SEL};
                            dout_q  <= cur_q.regn;
                        end else begin
                            cnt_q <= cnt_q + TO_W'(1);
                        end
                    end
                    ST_AWR: begin
                        state_q <= ST_AGAP;
                        cs_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                    end
                    ST_AGAP: begin
                        state_q <= ST_DPOLL;
                        cnt_q   <= '0;
                        cs_n_q  <= 1'b0;
                        addr_q  <= {cur_q.port, ADDR_SEL};
                    end
                    ST_DPOLL: begin
                        if (!busy_w || tmo_hit) begin
                            if (busy_w) busy_err_q <= 1'b1;
                            state_q <= ST_DWR;
                            wr_n_q  <= 1'b0;
                            addr_q  <= {cur_q.port, DATA_SEL};
                            dout_q  <= cur_q.val;
                        end else begin
                            cnt_q <= cnt_q + TO_W'(1);
                        end
                    end
                    ST_DWR: begin
                        state_q <= ST_DGAP;
                        cs_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cs_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign cs_n      = cs_n_q;
    assign wr_n      = wr_n_q;
    assign addr      = addr_q;
    assign bus_dout  = dout_q;
    assign idle      = idle_q;
    assign busy_err  = busy_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_jt12_bus_sequencer.sv
// Directed bench for jt12_bus_sequencer: every expected bus write is queued at
// push time and matched by a monitor on each falling edge of wr_n.
module tb_jt12_bus_sequencer;
  import jt12_bus_pkg::*;

  logic       mclk = 1'b0;
  logic       rst0 = 1'b1;
  logic       clk_en = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_port = 1'b0;
  logic [7:0] req_reg = 8'h00;
  logic [7:0] req_val = 8'h00;
  logic [7:0] bus_din = 8'h00;
  logic       req_ready, cs_n, wr_n, idle, busy_err;
  logic [1:0] addr;
  logic [7:0] bus_dout;
  state_e     dbg_state;

  int total = 0;
  int bad = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  int en_cnt = 0;
  int div = 0;
  bit en_enable = 1'b1;
  bit stuck = 1'b0;
  int busy_left = 0;
  int push_en = 0;
  int poll_start_en = 0;
  int last_wr_en = 0;
  int prev_wr_en = 0;
  int wr_falls = 0;
  int cs_low_cyc = 0;
  logic prev_wr_n = 1'b1;
  state_e prev_state = ST_IDLE;

  jt12_bus_sequencer #(.AW(4), .TIMEOUT(255)) dut (
    .mclk      (mclk),
    .rst0      (rst0),
    .clk_en    (clk_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_port  (req_port),
    .req_reg   (req_reg),
    .req_val   (req_val),
    .cs_n      (cs_n),
    .wr_n      (wr_n),
    .addr      (addr),
    .bus_dout  (bus_dout),
    .bus_din   (bus_din),
    .idle      (idle),
    .busy_err  (busy_err),
    .dbg_state (dbg_state)
  );

  // clock / clk_en / status source
  always #5 mclk = ~mclk;

  always @(negedge mclk) begin
    div = (div + 1) % 4;
    clk_en = en_enable && (div == 0);
    if (busy_left > 0 && dbg_state == ST_DPOLL && clk_en) begin
      bus_din = 8'h80;
      busy_left = busy_left - 1;
    end else begin
      bus_din = stuck ? 8'h95 : 8'h15;
    end
  end

  always @(posedge mclk) if (clk_en) en_cnt <= en_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge mclk) begin
    if (prev_wr_n && !wr_n) begin
      wr_falls++;
      prev_wr_en = last_wr_en;
      last_wr_en = en_cnt;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %0h expected none", {addr, bus_dout});
      end else begin
        mon_e = exp_q.pop_front();
        chk("bus_write", {22'd0, addr, bus_dout}, {22'd0, mon_e});
      end
    end
    if (!cs_n) cs_low_cyc++;
    if (dbg_state == ST_POLL && prev_state != ST_POLL) poll_start_en = en_cnt;
    prev_wr_n = wr_n;
    prev_state = dbg_state;
  end

  // driver tasks
  task automatic push(input logic p, input logic [7:0] r, input logic [7:0] v, output int held);
    @(negedge mclk);
    req_valid = 1'b1;
    req_port = p;
    req_reg = r;
    req_val = v;
    held = 0;
    while (!req_ready && held < 3000) begin
      @(negedge mclk);
      held++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got ready=0 expected ready=1");
      req_valid = 1'b0;
    end else begin
      @(posedge mclk);
      exp_q.push_back({p, ADDR_SEL, r});
      exp_q.push_back({p, DATA_SEL, v});
      #1;
      push_en = en_cnt;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int maxcyc);
    int n;
    n = 0;
    @(negedge mclk);
    while (!idle && n < maxcyc) begin
      @(negedge mclk);
      n++;
    end
    if (!idle) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got idle=0 expected idle=1");
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int held, pe, n, f0, c0;
    repeat (3) @(negedge mclk);
    rst0 = 1'b0;
    @(negedge mclk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_addr", addr, 0);
    chk("rst_dout", bus_dout, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_busy_err", busy_err, 0);

    // single write, port 0
    push(1'b0, 8'h28, 8'hF0, held);
    chk("idle_drop", idle, 0);
    pe = push_en;
    wait_idle(400);
    chk("first_poll", poll_start_en, pe + 1);
    chk("txn_len", en_cnt - poll_start_en, 6);
    chk("addr_data_gap", last_wr_en - prev_wr_en, 3);
    chk("dout_hold", {addr, bus_dout}, {2'b01, 8'hF0});

    // port 1
    push(1'b1, 8'h30, 8'h71, held);
    wait_idle(400);

    // busy for 10 polls in DPOLL
    busy_left = 10;
    push(1'b0, 8'hB4, 8'hC0, held);
    wait_idle(800);
    chk("busy_delay", last_wr_en - prev_wr_en, 13);
    chk("busy_err_clear", busy_err, 0);

    // fill with 17 pushes while clk_en is held low
    @(posedge mclk);
    #1;
    en_enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push(1'b0, 8'hA0 + 8'(i), 8'h10 + 8'(i), held);
      if (i == 0) chk("idle_low_queued", idle, 0);
    end
    chk("full_ready", req_ready, 0);
    chk("hold_en_low", {29'd0, dbg_state, cs_n}, {29'd0, ST_IDLE, 1'b1});
    fork
      begin
        repeat (20) @(negedge mclk);
        en_enable = 1'b1;
      end
    join_none
    push(1'b1, 8'hB0, 8'h5A, held);
    chk("fill_held", held >= 20, 1);
    wait_idle(4000);

    // busy stuck high: timeout on both polls
    stuck = 1'b1;
    push(1'b0, 8'h22, 8'h08, held);
    n = 0;
    while (!busy_err && n < 5000) begin
      @(negedge mclk);
      n++;
    end
    chk("timeout_polls", en_cnt - poll_start_en, 255);
    wait_idle(5000);
    chk("busy_err_set", busy_err, 1);
    stuck = 1'b0;
    push(1'b0, 8'h23, 8'h01, held);
    wait_idle(400);
    chk("busy_err_sticky", busy_err, 1);

    // reset during DWR
    push(1'b1, 8'h44, 8'h55, held);
    n = 0;
    while (dbg_state != ST_DWR && n < 400) begin
      @(negedge mclk);
      n++;
    end
    chk("reach_dwr", dbg_state, ST_DWR);
    #2;
    rst0 = 1'b1;
    #1;
    chk("arst_cs_n", cs_n, 1);
    chk("arst_wr_n", wr_n, 1);
    chk("arst_idle", idle, 1);
    chk("arst_busy_err", busy_err, 0);
    repeat (3) @(negedge mclk);
    rst0 = 1'b0;
    f0 = wr_falls;
    c0 = cs_low_cyc;
    repeat (200) @(negedge mclk);
    chk("no_strobe_after", wr_falls - f0, 0);
    chk("no_cs_after", cs_low_cyc - c0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
